// File: rtl/lv1_victim_ctrl.sv
// L1 miss/victim controller: picks a replacement way for a missing set, sequences
// writeback and fill, then touches the pseudo-LRU; processor hits share the LRU port.

`ifndef INDEX_MSB_LV1
`define INDEX_MSB_LV1 11
`endif
`ifndef INDEX_LSB_LV1
`define INDEX_LSB_LV1 5
`endif

module lv1_victim_ctrl #(
    parameter int ASSOC_WID = 2,
    parameter int INDEX_MSB = `INDEX_MSB_LV1,
    parameter int INDEX_LSB = `INDEX_LSB_LV1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         miss_req,
    input  logic [INDEX_MSB-INDEX_LSB:0] miss_index,
    output logic                         miss_ready,
    input  logic                         hit_valid,
    input  logic [INDEX_MSB-INDEX_LSB:0] hit_index,
    input  logic [ASSOC_WID-1:0]         hit_way,
    output logic                         hit_ready,
    input  logic [3:0]                   way_valid,
    input  logic [3:0]                   way_dirty,
    input  logic [ASSOC_WID-1:0]         lru_replacement_proc,
    output logic [INDEX_MSB-INDEX_LSB:0] index_proc,
    output logic                         lru_update,
    output logic [ASSOC_WID-1:0]         blk_accessed_main,
    output logic                         wb_req,
    input  logic                         wb_ack,
    output logic                         fill_req,
    input  logic                         fill_ack,
    output logic [ASSOC_WID-1:0]         victim_way,
    output logic                         done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_WB     = 3'd2,
        S_FILL   = 3'd3,
        S_UPD    = 3'd4
    } state_t;

    state_t                       r_state;
    logic [INDEX_MSB-INDEX_LSB:0] r_idx;
    logic [ASSOC_WID-1:0]         r_victim;
    logic                         r_wb_req;
    logic                         r_fill_req;
    logic                         r_done;

    logic [3:0]                   w_free;
    logic [ASSOC_WID-1:0]         w_victim;
    logic                         w_victim_dirty;
    logic                         w_hit_acc;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_free
            assign w_free[gi] = ~way_valid[gi];
        end
    endgenerate

    // An empty way always beats the LRU choice; lowest-numbered empty way wins.
    always_comb begin
        w_victim = lru_replacement_proc;
        for (int i = 3; i >= 0; i--) begin
            if (w_free[i]) begin
                w_victim = ASSOC_WID'(i);
            end
        end
    end

    assign w_victim_dirty = way_valid[w_victim] & way_dirty[w_victim];

    assign miss_ready = (r_state == S_IDLE);
    assign hit_ready  = (r_state != S_SELECT) && (r_state != S_UPD);
    // Hits are held off while reset is asserted so the LRU port stays quiet.
    assign w_hit_acc  = hit_valid & hit_ready & rst_n;

    always_comb begin
        index_proc = r_idx;
        if (r_state == S_IDLE) begin
            index_proc = miss_index;
        end
        if (w_hit_acc) begin
            index_proc = hit_index;
        end
    end

    always_comb begin
        lru_update        = 1'b0;
        blk_accessed_main = '0;
        if (w_hit_acc) begin
            lru_update        = 1'b1;
            blk_accessed_main = hit_way;
        end else if (r_done) begin
            lru_update        = 1'b1;
            blk_accessed_main = r_victim;
        end
    end

    assign wb_req     = r_wb_req;
    assign fill_req   = r_fill_req;
    assign done       = r_done;
    assign victim_way = r_victim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_victim   <= '0;
            r_wb_req   <= 1'b0;
            r_fill_req <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (miss_req) begin
                        r_idx   <= miss_index;
                        r_state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    r_victim <= w_victim;
                    if (w_victim_dirty) begin
                        r_state  <= S_WB;
                        r_wb_req <= 1'b1;
                    end else begin
                        r_state    <= S_FILL;
                        r_fill_req <= 1'b1;
                    end
                end
                S_WB: begin
                    if (wb_ack) begin
                        r_state    <= S_FILL;
                        r_wb_req   <= 1'b0;
                        r_fill_req <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (fill_ack) begin
                        r_state    <= S_UPD;
                        r_fill_req <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                S_UPD: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wb_req   <= 1'b0;
                    r_fill_req <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lv1_victim_ctrl.sv
// Bench for lv1_victim_ctrl: per-miss expectations are queued by the stimulus and
// a negedge monitor compares every cycle against a timeline derived from them.

module tb_lv1_victim_ctrl;

    localparam int IW = 7;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miss_req = 1'b0;
    logic [IW-1:0] miss_index = '0;
    logic          miss_ready;
    logic          hit_valid = 1'b0;
    logic [IW-1:0] hit_index = '0;
    logic [AW-1:0] hit_way = '0;
    logic          hit_ready;
    logic [3:0]    way_valid;
    logic [3:0]    way_dirty;
    logic [AW-1:0] lru_replacement_proc;
    logic [IW-1:0] index_proc;
    logic          lru_update;
    logic [AW-1:0] blk_accessed_main;
    logic          wb_req;
    logic          wb_ack = 1'b0;
    logic          fill_req;
    logic          fill_ack = 1'b0;
    logic [AW-1:0] victim_way;
    logic          done;

    lv1_victim_ctrl #(.ASSOC_WID(AW), .INDEX_MSB(11), .INDEX_LSB(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_req(miss_req), .miss_index(miss_index), .miss_ready(miss_ready),
        .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way), .hit_ready(hit_ready),
        .way_valid(way_valid), .way_dirty(way_dirty), .lru_replacement_proc(lru_replacement_proc),
        .index_proc(index_proc), .lru_update(lru_update), .blk_accessed_main(blk_accessed_main),
        .wb_req(wb_req), .wb_ack(wb_ack), .fill_req(fill_req), .fill_ack(fill_ack),
        .victim_way(victim_way), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tag/LRU array model, looked up by whatever set the controller presents.
    logic [3:0]    valid_arr [128];
    logic [3:0]    dirty_arr [128];
    logic [AW-1:0] lru_arr   [128];
    assign way_valid            = valid_arr[index_proc];
    assign way_dirty            = dirty_arr[index_proc];
    assign lru_replacement_proc = lru_arr[index_proc];

    typedef struct {
        int            n;
        logic [IW-1:0] idx;
        logic [AW-1:0] victim;
        int            wbcyc;
        int            fillcyc;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory-side responder: ack after a programmed number of request cycles.
    int wb_delay_cur = 0, fill_delay_cur = 0, wb_cnt = 0, fill_cnt = 0;
    bit stray_wb = 0, stray_fill = 0;
    always @(posedge clk) begin
        #1;
        if (wb_req) begin
            wb_ack = (wb_cnt == wb_delay_cur);
            wb_cnt++;
        end else begin
            wb_ack = stray_wb;
            wb_cnt = 0;
        end
        if (fill_req) begin
            fill_ack = (fill_cnt == fill_delay_cur);
            fill_cnt++;
        end else begin
            fill_ack = stray_fill;
            fill_cnt = 0;
        end
    end

    // Monitor: expected phase of the outstanding miss is pure cycle arithmetic.
    always @(negedge clk) begin
        int rel;
        bit e_mr, e_hr, e_wb, e_fill, e_done, e_upd, c_idx, c_blk, c_vic, pop;
        logic [IW-1:0] e_idx;
        logic [AW-1:0] e_blk;
        if (rst_n) begin
            e_mr = 1; e_hr = 1; e_wb = 0; e_fill = 0; e_done = 0; e_upd = 0;
            c_idx = 1; c_blk = 0; c_vic = 0; pop = 0;
            e_idx = miss_index; e_blk = '0;
            if (q.size() > 0 && cyc > q[0].n) begin
                rel  = cyc - q[0].n;
                e_mr = 0;
                c_vic = (rel >= 2);
                if (rel == 1) begin
                    e_hr = 0; e_idx = q[0].idx;
                end else if (rel <= 1 + q[0].wbcyc) begin
                    e_wb = 1; c_idx = 0;
                end else if (rel <= 1 + q[0].wbcyc + q[0].fillcyc) begin
                    e_fill = 1; c_idx = 0;
                end else begin
                    e_hr = 0; e_done = 1; e_upd = 1; e_idx = q[0].idx;
                    e_blk = q[0].victim; c_blk = 1; pop = 1;
                end
            end
            if (hit_valid && e_hr) begin
                e_upd = 1; e_idx = hit_index; c_idx = 1; e_blk = hit_way; c_blk = 1;
            end
            chk("miss_ready", 32'(miss_ready), 32'(e_mr));
            chk("hit_ready", 32'(hit_ready), 32'(e_hr));
            chk("wb_req", 32'(wb_req), 32'(e_wb));
            chk("fill_req", 32'(fill_req), 32'(e_fill));
            chk("done", 32'(done), 32'(e_done));
            chk("lru_update", 32'(lru_update), 32'(e_upd));
            if (c_idx) chk("index_proc", 32'(index_proc), 32'(e_idx));
            if (c_blk) chk("blk_accessed_main", 32'(blk_accessed_main), 32'(e_blk));
            if (c_vic) chk("victim_way", 32'(victim_way), 32'(q[0].victim));
            if (pop) begin
                $display("[TB] miss idx=%0d victim=%0d wb_cycles=%0d fill_cycles=%0d done at cycle %0d",
                         q[0].idx, q[0].victim, q[0].wbcyc, q[0].fillcyc, cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_hit(input bit en);
        hit_valid = en ? 1'($urandom_range(0, 1)) : 1'b0;
        hit_index = IW'($urandom);
        hit_way   = AW'($urandom);
    endtask

    // Issue one miss at the current cycle (controller must be idle) and follow it to completion.
    task automatic do_miss(input logic [IW-1:0] idx, input logic [3:0] v, input logic [3:0] d,
                           input logic [AW-1:0] lru, input int wbd, input int fd,
                           input bit hit_now, input logic [IW-1:0] hidx, input logic [AW-1:0] hway,
                           input bit hit_sel, input bit rand_hits, input int abort_rel);
        exp_t e;
        logic [AW-1:0] vic;
        bit wb;
        int r;
        valid_arr[idx] = v; dirty_arr[idx] = d; lru_arr[idx] = lru;
        vic = lru;
        for (int i = 3; i >= 0; i--) if (!v[i]) vic = AW'(i);
        wb = v[vic] && d[vic];
        wb_delay_cur = wbd; fill_delay_cur = fd;
        e.n = cyc; e.idx = idx; e.victim = vic;
        e.wbcyc = wb ? wbd + 1 : 0; e.fillcyc = fd + 1;
        q.push_back(e);
        miss_req = 1'b1; miss_index = idx;
        if (hit_now) begin
            hit_valid = 1'b1; hit_index = hidx; hit_way = hway;
        end else rand_hit(rand_hits);
        r = 1;
        while (q.size() > 0 && r < 400) begin
            tick();
            if (r == abort_rel) begin
                rst_n = 1'b0; q.delete(); miss_req = 1'b0; hit_valid = 1'b0;
                #1;
                chk("abort wb_req", 32'(wb_req), 32'd0);
                chk("abort fill_req", 32'(fill_req), 32'd0);
                chk("abort done", 32'(done), 32'd0);
                chk("abort lru_update", 32'(lru_update), 32'd0);
                chk("abort miss_ready", 32'(miss_ready), 32'd1);
                chk("abort victim_way", 32'(victim_way), 32'd0);
                $display("[TB] reset applied %0d cycles into miss idx=%0d", r, idx);
                tick();
                rst_n = 1'b1;
                break;
            end
            // A held/stray request during SELECT must be ignored.
            miss_req = (r == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (r == 1) miss_index = IW'($urandom);
            if (r == 1 && hit_sel) begin
                hit_valid = 1'b1; hit_index = IW'($urandom); hit_way = AW'($urandom);
            end else rand_hit(rand_hits);
            r++;
        end
        if (q.size() > 0) begin
            chk("miss timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        miss_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            valid_arr[i] = 4'($urandom); dirty_arr[i] = 4'($urandom); lru_arr[i] = AW'($urandom);
        end
        #1;
        chk("reset miss_ready", 32'(miss_ready), 32'd1);
        chk("reset hit_ready", 32'(hit_ready), 32'd1);
        chk("reset wb_req", 32'(wb_req), 32'd0);
        chk("reset fill_req", 32'(fill_req), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset lru_update", 32'(lru_update), 32'd0);
        chk("reset blk", 32'(blk_accessed_main), 32'd0);
        chk("reset victim_way", 32'(victim_way), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        // V1: free way 2, acks immediate
        do_miss(7'd5, 4'b1011, 4'b0000, 2'd0, 0, 0, 0, '0, '0, 0, 0, 0);
        // V2: dirty LRU victim, slow writeback
        do_miss(7'd9, 4'b1111, 4'b1000, 2'd3, 4, 0, 0, '0, '0, 0, 0, 0);
        // V3: clean LRU victim
        do_miss(7'd9, 4'b1111, 4'b0111, 2'd3, 4, 0, 0, '0, '0, 0, 0, 0);
        // V4: hit alongside miss accept, then a hit during SELECT
        do_miss(7'd20, 4'b1111, 4'b0000, 2'd2, 0, 1, 1, 7'd7, 2'd1, 1, 0, 0);
        // V5: reset while waiting for writeback, then a normal miss
        do_miss(7'd33, 4'b1111, 4'b1111, 2'd1, 10, 0, 0, '0, '0, 0, 0, 4);
        tick();
        do_miss(7'd33, 4'b0111, 4'b0000, 2'd1, 0, 0, 0, '0, '0, 0, 0, 0);
        // V6: stray fill_ack while idle, stray wb_ack during fill
        stray_fill = 1;
        for (int i = 0; i < 3; i++) begin
            miss_index = IW'($urandom);
            tick();
        end
        stray_fill = 0; stray_wb = 1;
        do_miss(7'd44, 4'b1101, 4'b1111, 2'd0, 0, 3, 0, '0, '0, 0, 0, 0);
        stray_wb = 0;

        // Randomized misses with background hits
        for (int k = 0; k < 40; k++) begin
            do_miss(IW'($urandom), 4'($urandom), 4'($urandom), AW'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    IW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)), 1, 0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        hit_valid = 1'b0;
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
